// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
// Module   : instr_fetch_ctrl
// Brief    : PC consumer; fetches from instruction memory and hands words to the
//            decoder over valid/ready, steering PC via inc / write_en / data.
//            Optional macro FETCH_TIMEOUT_EN enables the WAIT timeout and fetch_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_ctrl #(
   parameter int ADDR_W         = 16,
   parameter int INSTR_W        = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic [ADDR_W-1:0]  pc_addr_i,
   output logic               pc_inc_o,
   output logic               pc_write_en_o,
   output logic [ADDR_W-1:0]  pc_data_o,
   input  logic               branch_req_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic               halt_i,
   output logic               mem_rd_en_o,
   output logic [ADDR_W-1:0]  mem_addr_o,
   input  logic               mem_rd_valid_i,
   input  logic [INSTR_W-1:0] mem_rd_data_i,
   output logic [INSTR_W-1:0] instr_out_o,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic               fetch_err_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_HOLD   = 3'd3,
      S_BRANCH = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 flush_q, flush_d;
   logic                 pc_inc_q, pc_inc_d;
   logic                 pc_write_en_q, pc_write_en_d;
   logic [ADDR_W-1:0]    pc_data_q, pc_data_d;
   logic                 mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [INSTR_W-1:0]   instr_out_q, instr_out_d;
   logic                 instr_valid_q, instr_valid_d;
   logic                 xfer;
   logic                 tmo_hit;

   assign xfer = instr_valid_q && instr_ready_i;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             fetch_err_q;

   assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         tmo_cnt_q   <= '0;
         fetch_err_q <= 1'b0;
      end else if (state_q == S_REQ) begin
         tmo_cnt_q   <= '0;
      end else if (state_q == S_WAIT && !mem_rd_valid_i) begin
         tmo_cnt_q   <= tmo_cnt_q + CNT_W'(1);
         if (tmo_hit) begin
            fetch_err_q <= 1'b1;
         end
      end
   end

   assign fetch_err_o = fetch_err_q;
`else
   logic timeout_unused;

   assign tmo_hit        = 1'b0;
   assign timeout_unused = (TIMEOUT_CYCLES != 0);
   assign fetch_err_o    = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      flush_d       = flush_q;
      pc_inc_d      = 1'b0;
      pc_write_en_d = 1'b0;
      pc_data_d     = pc_data_q;
      mem_rd_en_d   = 1'b0;
      mem_addr_d    = mem_addr_q;
      instr_out_d   = instr_out_q;
      instr_valid_d = instr_valid_q;

      case (state_q)
         S_IDLE: begin
            if (branch_req_i) begin
               state_d = S_BRANCH;
            end else if (!halt_i) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = pc_addr_i;
            state_d     = S_WAIT;
            if (branch_req_i) begin
               flush_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_rd_valid_i) begin
               if (branch_req_i) begin
                  flush_d = 1'b0;
                  state_d = S_BRANCH;
               end else if (flush_q) begin
                  flush_d = 1'b0;
                  state_d = halt_i ? S_IDLE : S_REQ;
               end else begin
                  instr_out_d   = mem_rd_data_i;
                  instr_valid_d = 1'b1;
                  pc_inc_d      = 1'b1;
                  state_d       = S_HOLD;
               end
            end else if (tmo_hit) begin
               // Abandoned read: a pending branch still needs the BRANCH slot for PC to load.
               flush_d = 1'b0;
               state_d = branch_req_i ? S_BRANCH : S_REQ;
            end else if (branch_req_i) begin
               flush_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (branch_req_i) begin
               instr_valid_d = 1'b0;
               state_d       = S_BRANCH;
            end else if (xfer) begin
               instr_valid_d = 1'b0;
               state_d       = halt_i ? S_IDLE : S_REQ;
            end
         end
         S_BRANCH: begin
            if (!branch_req_i) begin
               state_d = halt_i ? S_IDLE : S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Branch target load always takes priority over sequential advance.
      if (branch_req_i) begin
         pc_data_d     = branch_target_i;
         pc_write_en_d = 1'b1;
         pc_inc_d      = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         flush_q       <= 1'b0;
         pc_inc_q      <= 1'b0;
         pc_write_en_q <= 1'b0;
         pc_data_q     <= '0;
         mem_rd_en_q   <= 1'b0;
         mem_addr_q    <= '0;
         instr_out_q   <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_q       <= flush_d;
         pc_inc_q      <= pc_inc_d;
         pc_write_en_q <= pc_write_en_d;
         pc_data_q     <= pc_data_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_addr_q    <= mem_addr_d;
         instr_out_q   <= instr_out_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign pc_inc_o      = pc_inc_q;
   assign pc_write_en_o = pc_write_en_q;
   assign pc_data_o     = pc_data_q;
   assign mem_rd_en_o   = mem_rd_en_q;
   assign mem_addr_o    = mem_addr_q;
   assign instr_out_o   = instr_out_q;
   assign instr_valid_o = instr_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Brief    : Directed bench for instr_fetch_ctrl with PC and memory environment models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [15:0] pc_addr_i;
   logic        pc_inc_o;
   logic        pc_write_en_o;
   logic [15:0] pc_data_o;
   logic        branch_req_i = 1'b0;
   logic [15:0] branch_target_i = 16'h0000;
   logic        halt_i = 1'b0;
   logic        mem_rd_en_o;
   logic [15:0] mem_addr_o;
   logic        mem_rd_valid_i = 1'b0;
   logic [15:0] mem_rd_data_i = 16'h0000;
   logic [15:0] instr_out_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic        fetch_err_o;

   int n_vec = 0;
   int n_err = 0;

   instr_fetch_ctrl #(
      .ADDR_W         (16),
      .INSTR_W        (16),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .pc_addr_i       (pc_addr_i),
      .pc_inc_o        (pc_inc_o),
      .pc_write_en_o   (pc_write_en_o),
      .pc_data_o       (pc_data_o),
      .branch_req_i    (branch_req_i),
      .branch_target_i (branch_target_i),
      .halt_i          (halt_i),
      .mem_rd_en_o     (mem_rd_en_o),
      .mem_addr_o      (mem_addr_o),
      .mem_rd_valid_i  (mem_rd_valid_i),
      .mem_rd_data_i   (mem_rd_data_i),
      .instr_out_o     (instr_out_o),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .fetch_err_o     (fetch_err_o)
   );

   always #5 clock_i = ~clock_i;

   // Program counter model
   logic [15:0] pc = 16'h0002;
   always @(posedge clock_i) begin
      if (pc_write_en_o)  pc <= pc_data_o;
      else if (pc_inc_o)  pc <= pc + 16'h0001;
   end
   assign pc_addr_i = pc;

   // Memory model: data word = address ^ 16'hC3A0, latency in cycles after sampling rd_en
   int          mem_lat = 1;
   bit          silent  = 1'b0;
   int          mcnt    = 0;
   logic [15:0] maddr   = 16'h0000;
   always @(posedge clock_i) begin
      mem_rd_valid_i <= 1'b0;
      if (mem_rd_en_o && !silent) begin
         maddr <= mem_addr_o;
         if (mem_lat <= 1) begin
            mem_rd_valid_i <= 1'b1;
            mem_rd_data_i  <= mem_addr_o ^ 16'hC3A0;
            mcnt           <= 0;
         end else begin
            mcnt <= mem_lat - 1;
         end
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) begin
            mem_rd_valid_i <= 1'b1;
            mem_rd_data_i  <= maddr ^ 16'hC3A0;
         end
      end
   end

   bit both_seen = 1'b0;
   always @(posedge clock_i) begin
      if (pc_inc_o && pc_write_en_o) both_seen <= 1'b1;
   end

   typedef struct packed {
      logic        rdy;
      logic        rd_en;
      logic [15:0] addr;
      logic        valid;
      logic [15:0] instr;
      logic        inc;
      logic        wen;
   } vec_t;

   vec_t tbl [21];

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  bad;
      logic [15:0] exp_addr;

      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'hC3A2, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 16'hC3A2, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 16'h0003, 1'b0, 16'hC3A2, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 16'h0003, 1'b0, 16'hC3A2, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 16'hC3A3, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 16'h0003, 1'b0, 16'hC3A3, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'hC3A3, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 16'h0004, 1'b0, 16'hC3A3, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'hC3A4, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'hC3A4, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'hC3A4, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'hC3A4, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'hC3A4, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'hC3A4, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 16'h0004, 1'b0, 16'hC3A4, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 1'b1, 16'h0005, 1'b0, 16'hC3A4, 1'b0, 1'b0};
      tbl[19] = '{1'b1, 1'b0, 16'h0005, 1'b0, 16'hC3A4, 1'b0, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 16'h0005, 1'b1, 16'hC3A5, 1'b1, 1'b0};

      // Reset state
      tick();
      tick();
      chk("reset_outputs",
          {pc_inc_o, pc_write_en_o, pc_data_o, mem_rd_en_o, mem_addr_o,
           instr_out_o, instr_valid_o, fetch_err_o}, 64'h0);
      reset_i = 1'b0;

      // Sequential fetch from 0x0002, then decoder stall in HOLD
      for (int i = 0; i < 21; i++) begin
         instr_ready_i = tbl[i].rdy;
         tick();
         chk($sformatf("seq_row%0d", i),
             {mem_rd_en_o, mem_addr_o, instr_valid_o, instr_out_o, pc_inc_o, pc_write_en_o},
             {tbl[i].rd_en, tbl[i].addr, tbl[i].valid, tbl[i].instr, tbl[i].inc, tbl[i].wen});
      end

      // Branch in HOLD to 0x0008
      instr_ready_i   = 1'b0;
      branch_req_i    = 1'b1;
      branch_target_i = 16'h0008;
      tick();
      chk("hold_branch_pulse", {pc_write_en_o, pc_data_o, instr_valid_o, pc_inc_o},
          {1'b1, 16'h0008, 1'b0, 1'b0});
      branch_req_i = 1'b0;
      tick();
      chk("hold_branch_slot", {pc_write_en_o, mem_rd_en_o}, {1'b0, 1'b0});
      tick();
      chk("hold_branch_fetch", {mem_rd_en_o, mem_addr_o}, {1'b1, 16'h0008});
      instr_ready_i = 1'b1;
      n = 0;
      while (!instr_valid_o && n < 20) begin tick(); n++; end
      chk("hold_branch_instr", {instr_valid_o, instr_out_o}, {1'b1, 16'hC3A8});

      // Branch in WAIT, data returns 3 cycles later and is discarded
      mem_lat = 3;
      n = 0;
      while (!mem_rd_en_o && n < 20) begin tick(); n++; end
      chk("wait_rd_en_0009", {mem_rd_en_o, mem_addr_o}, {1'b1, 16'h0009});
      branch_req_i    = 1'b1;
      branch_target_i = 16'h0010;
      tick();
      chk("wait_branch_pulse", {pc_write_en_o, pc_data_o, pc_inc_o}, {1'b1, 16'h0010, 1'b0});
      branch_req_i = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         bad = bad | instr_valid_o | pc_inc_o | mem_rd_en_o;
      end
      chk("wait_branch_discard", {63'h0, bad}, 64'h0);
      tick();
      chk("wait_branch_refetch", {mem_rd_en_o, mem_addr_o}, {1'b1, 16'h0010});
      n = 0;
      while (!instr_valid_o && n < 20) begin tick(); n++; end
      chk("wait_branch_instr", {instr_valid_o, instr_out_o}, {1'b1, 16'hC3B0});

      // Branch in the same cycle as mem_rd_valid
      mem_lat = 1;
      n = 0;
      while (!mem_rd_en_o && n < 20) begin tick(); n++; end
      chk("coinc_rd_en_0011", {mem_rd_en_o, mem_addr_o}, {1'b1, 16'h0011});
      tick();
      branch_req_i    = 1'b1;
      branch_target_i = 16'h0020;
      tick();
      chk("coinc_branch", {instr_valid_o, pc_inc_o, pc_write_en_o, pc_data_o},
          {1'b0, 1'b0, 1'b1, 16'h0020});
      branch_req_i = 1'b0;
      tick();
      tick();
      chk("coinc_refetch", {mem_rd_en_o, mem_addr_o}, {1'b1, 16'h0020});

      // Halt during WAIT: instruction delivered, then idle until halt released
      halt_i = 1'b1;
      n = 0;
      while (!instr_valid_o && n < 20) begin tick(); n++; end
      chk("halt_instr", {instr_valid_o, instr_out_o}, {1'b1, 16'hC380});
      tick();
      chk("halt_xfer_drop", {63'h0, instr_valid_o}, 64'h0);
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         bad = bad | mem_rd_en_o | instr_valid_o;
      end
      chk("halt_idle_quiet", {63'h0, bad}, 64'h0);
      halt_i = 1'b0;
      n = 0;
      while (!mem_rd_en_o && n < 4) begin tick(); n++; end
      chk("halt_release_fetch", {mem_rd_en_o, mem_addr_o}, {1'b1, 16'h0021});

      // Reset asserted mid-read; the late response must be ignored
      mem_lat = 3;
      halt_i  = 1'b1;
      tick();
      #2 reset_i = 1'b1;
      #1;
      chk("async_reset_outputs",
          {pc_inc_o, pc_write_en_o, pc_data_o, mem_rd_en_o, mem_addr_o,
           instr_out_o, instr_valid_o, fetch_err_o}, 64'h0);
      #3 reset_i = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         bad = bad | instr_valid_o | mem_rd_en_o | pc_inc_o;
      end
      chk("late_valid_ignored", {63'h0, bad}, 64'h0);

      // Silent memory: timeout behaviour depends on the build
      silent = 1'b1;
      halt_i = 1'b0;
      exp_addr = pc;
      n = 0;
      while (!mem_rd_en_o && n < 6) begin tick(); n++; end
      chk("silent_rd_en", {mem_rd_en_o, mem_addr_o}, {1'b1, exp_addr});
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) tick();
      chk("timeout_not_yet", {63'h0, fetch_err_o}, 64'h0);
      tick();
      chk("timeout_err_set", {63'h0, fetch_err_o}, 64'h1);
      tick();
      chk("timeout_reissue", {mem_rd_en_o, mem_addr_o, fetch_err_o}, {1'b1, exp_addr, 1'b1});
`else
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         bad = bad | mem_rd_en_o | fetch_err_o | instr_valid_o;
      end
      chk("no_timeout_stuck_wait", {63'h0, bad}, 64'h0);
`endif

      chk("inc_and_wen_exclusive", {63'h0, both_seen}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
